// File: rtl/multilatch_ctr_if.sv
// Bus bundle for multilatch_ctr: capture input, op controls, output enables and status.
interface multilatch_ctr_if #(
  parameter int WIDTH = 12,
  parameter int NOUT  = 2
);
  logic [WIDTH-1:0]      in;
  logic                  hold;
  logic                  latch;
  logic [1:0]            op;
  logic [NOUT-1:0]       oe;
  logic [NOUT*WIDTH-1:0] out;
  logic                  link;
  logic                  zero;

  modport master (
    output in, hold, latch, op, oe,
    input  out, link, zero
  );

  modport slave (
    input  in, hold, latch, op, oe,
    output out, link, zero
  );
endinterface

// File: rtl/multilatch_ctr.sv
// Two-stage register (capture + data) with load/clear/inc/dec ops and NOUT enabled outputs.
// Define MULTILATCH_TRISTATE_EN to make disabled channels drive 'z instead of zeros.
module multilatch_ctr #(
  parameter int WIDTH = 12,
  parameter int NOUT  = 2
) (
  input  logic            SYSCLK,
  input  logic            RESET_N,
  multilatch_ctr_if.slave bus
);
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_INC   = 2'b10;
  localparam logic [1:0] OP_DEC   = 2'b11;

  logic [WIDTH-1:0]      holdreg;
  logic [WIDTH-1:0]      data;
  logic                  link_q;
  logic [NOUT*WIDTH-1:0] out_v;

  // LOAD reads holdreg before this edge's capture, so no in->data bypass exists.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      holdreg <= '0;
      data    <= '0;
      link_q  <= 1'b0;
    end else begin
      if (!bus.hold)
        holdreg <= bus.in;
      if (bus.latch) begin
        case (bus.op)
          OP_LOAD: begin
            data   <= holdreg;
            link_q <= 1'b0;
          end
          OP_CLEAR: begin
            data   <= '0;
            link_q <= 1'b0;
          end
          OP_INC: begin
            data <= data + WIDTH'(1);
            if (data == '1)
              link_q <= 1'b1;
          end
          OP_DEC: begin
            data <= data - WIDTH'(1);
            if (data == '0)
              link_q <= 1'b1;
          end
          default: begin
            data   <= data;
            link_q <= link_q;
          end
        endcase
      end
    end
  end

  always_comb begin
    out_v = '0;
    for (int unsigned k = 0; k < NOUT; k++) begin
`ifdef MULTILATCH_TRISTATE_EN
      out_v[k*WIDTH +: WIDTH] = bus.oe[k] ? data : {WIDTH{1'bz}};
`else
      out_v[k*WIDTH +: WIDTH] = bus.oe[k] ? data : '0;
`endif
    end
  end

  assign bus.out  = out_v;
  assign bus.link = link_q;
  assign bus.zero = (data == '0);
endmodule

// File: tb/tb_multilatch_ctr.sv
// Directed-vector bench for multilatch_ctr (WIDTH=12, NOUT=2).
module tb_multilatch_ctr;
  localparam int WIDTH = 12;
  localparam int NOUT  = 2;

  logic SYSCLK;
  logic RESET_N;
  int   vectors;
  int   miscompares;

  multilatch_ctr_if #(.WIDTH(WIDTH), .NOUT(NOUT)) bus ();

  multilatch_ctr #(.WIDTH(WIDTH), .NOUT(NOUT)) dut (
    .SYSCLK  (SYSCLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

`ifdef MULTILATCH_TRISTATE_EN
  localparam logic [WIDTH-1:0] DIS = {WIDTH{1'bz}};
`else
  localparam logic [WIDTH-1:0] DIS = '0;
`endif

  localparam logic [1:0] LOAD  = 2'b00;
  localparam logic [1:0] CLEAR = 2'b01;
  localparam logic [1:0] INC   = 2'b10;
  localparam logic [1:0] DEC   = 2'b11;

  task automatic step();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic apply(input logic h, input logic [WIDTH-1:0] v, input logic l, input logic [1:0] o);
    bus.hold  = h;
    bus.in    = v;
    bus.latch = l;
    bus.op    = o;
    step();
  endtask

  task automatic test_reset();
    bus.oe = 2'b11;
    apply(1'b1, '0, 1'b0, LOAD);
    apply(1'b1, '0, 1'b0, LOAD);
    #3;
    RESET_N = 1'b0;
    #1;
    vectors++;
    if (bus.out[0 +: WIDTH] !== 12'o0000) begin
      miscompares++;
      $display("FAIL reset_ch0: got %o expected %o", bus.out[0 +: WIDTH], 12'o0000);
    end
    vectors++;
    if (bus.out[WIDTH +: WIDTH] !== 12'o0000) begin
      miscompares++;
      $display("FAIL reset_ch1: got %o expected %o", bus.out[WIDTH +: WIDTH], 12'o0000);
    end
    vectors++;
    if (bus.link !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_link: got %b expected 0", bus.link);
    end
    vectors++;
    if (bus.zero !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_zero: got %b expected 1", bus.zero);
    end
    #2;
    RESET_N = 1'b1;
  endtask

  task automatic test_pipeline();
    apply(1'b0, 12'o1234, 1'b0, LOAD);
    vectors++;
    if (bus.out[0 +: WIDTH] !== 12'o0000) begin
      miscompares++;
      $display("FAIL pipe_edge1: got %o expected %o", bus.out[0 +: WIDTH], 12'o0000);
    end
    apply(1'b1, 12'o0000, 1'b1, LOAD);
    vectors++;
    if (bus.out[0 +: WIDTH] !== 12'o1234) begin
      miscompares++;
      $display("FAIL pipe_edge2: got %o expected %o", bus.out[0 +: WIDTH], 12'o1234);
    end
    apply(1'b0, 12'o7777, 1'b1, LOAD);
    vectors++;
    if (bus.out[0 +: WIDTH] !== 12'o1234) begin
      miscompares++;
      $display("FAIL no_bypass: got %o expected %o", bus.out[0 +: WIDTH], 12'o1234);
    end
  endtask

  task automatic test_wrap();
    apply(1'b1, '0, 1'b1, LOAD);
    vectors++;
    if (bus.out[0 +: WIDTH] !== 12'o7777) begin
      miscompares++;
      $display("FAIL load_7777: got %o expected %o", bus.out[0 +: WIDTH], 12'o7777);
    end
    apply(1'b1, '0, 1'b1, INC);
    vectors++;
    if ({bus.out[0 +: WIDTH], bus.link, bus.zero} !== {12'o0000, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL inc_wrap: got data=%o link=%b zero=%b expected data=0000 link=1 zero=1",
               bus.out[0 +: WIDTH], bus.link, bus.zero);
    end
    apply(1'b1, '0, 1'b1, INC);
    vectors++;
    if ({bus.out[0 +: WIDTH], bus.link, bus.zero} !== {12'o0001, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL inc_sticky: got data=%o link=%b zero=%b expected data=0001 link=1 zero=0",
               bus.out[0 +: WIDTH], bus.link, bus.zero);
    end
    apply(1'b1, '0, 1'b1, CLEAR);
    vectors++;
    if ({bus.out[0 +: WIDTH], bus.link} !== {12'o0000, 1'b0}) begin
      miscompares++;
      $display("FAIL clear_link: got data=%o link=%b expected data=0000 link=0",
               bus.out[0 +: WIDTH], bus.link);
    end
  endtask

  task automatic test_dec_wrap();
    apply(1'b1, '0, 1'b1, CLEAR);
    apply(1'b1, '0, 1'b1, DEC);
    vectors++;
    if ({bus.out[0 +: WIDTH], bus.link} !== {12'o7777, 1'b1}) begin
      miscompares++;
      $display("FAIL dec_wrap: got data=%o link=%b expected data=7777 link=1",
               bus.out[0 +: WIDTH], bus.link);
    end
    apply(1'b1, '0, 1'b1, DEC);
    vectors++;
    if ({bus.out[0 +: WIDTH], bus.link} !== {12'o7776, 1'b1}) begin
      miscompares++;
      $display("FAIL dec_step: got data=%o link=%b expected data=7776 link=1",
               bus.out[0 +: WIDTH], bus.link);
    end
    apply(1'b0, 12'o0005, 1'b0, LOAD);
    vectors++;
    if (bus.out[0 +: WIDTH] !== 12'o7776) begin
      miscompares++;
      $display("FAIL latch_idle: got %o expected %o", bus.out[0 +: WIDTH], 12'o7776);
    end
    apply(1'b1, '0, 1'b1, LOAD);
    vectors++;
    if ({bus.out[0 +: WIDTH], bus.link} !== {12'o0005, 1'b0}) begin
      miscompares++;
      $display("FAIL load_clears_link: got data=%o link=%b expected data=0005 link=0",
               bus.out[0 +: WIDTH], bus.link);
    end
  endtask

  task automatic test_oe();
    apply(1'b0, 12'o5252, 1'b0, LOAD);
    apply(1'b1, '0, 1'b1, LOAD);
    bus.latch = 1'b0;
    bus.oe = 2'b10;
    #1;
    vectors++;
    if (bus.out[WIDTH +: WIDTH] !== 12'o5252) begin
      miscompares++;
      $display("FAIL oe10_ch1: got %o expected %o", bus.out[WIDTH +: WIDTH], 12'o5252);
    end
    vectors++;
    if (bus.out[0 +: WIDTH] !== DIS) begin
      miscompares++;
      $display("FAIL oe10_ch0: got %o expected %o", bus.out[0 +: WIDTH], DIS);
    end
    bus.oe = 2'b01;
    #1;
    vectors++;
    if ({bus.out[WIDTH +: WIDTH], bus.out[0 +: WIDTH]} !== {DIS, 12'o5252}) begin
      miscompares++;
      $display("FAIL oe01: got %o expected %o", bus.out, {DIS, 12'o5252});
    end
    bus.oe = 2'b00;
    #1;
    vectors++;
    if ({bus.out, bus.zero} !== {DIS, DIS, 1'b0}) begin
      miscompares++;
      $display("FAIL oe00: got out=%o zero=%b expected out=%o zero=0", bus.out, bus.zero, {DIS, DIS});
    end
    bus.oe = 2'b11;
  endtask

  task automatic test_reset_mid();
    bus.oe = 2'b11;
    for (int i = 0; i < 5; i++)
      apply(1'b1, '0, 1'b1, INC);
    vectors++;
    if (bus.out[0 +: WIDTH] !== 12'o5257) begin
      miscompares++;
      $display("FAIL free_run: got %o expected %o", bus.out[0 +: WIDTH], 12'o5257);
    end
    #3;
    RESET_N = 1'b0;
    #1;
    vectors++;
    if ({bus.out[0 +: WIDTH], bus.zero, bus.link} !== {12'o0000, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid: got data=%o zero=%b link=%b expected data=0000 zero=1 link=0",
               bus.out[0 +: WIDTH], bus.zero, bus.link);
    end
    #2;
    RESET_N = 1'b1;
    apply(1'b1, '0, 1'b1, INC);
    vectors++;
    if ({bus.out[0 +: WIDTH], bus.link} !== {12'o0001, 1'b0}) begin
      miscompares++;
      $display("FAIL after_release: got data=%o link=%b expected data=0001 link=0",
               bus.out[0 +: WIDTH], bus.link);
    end
    bus.latch = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RESET_N     = 1'b1;
    bus.in      = '0;
    bus.hold    = 1'b1;
    bus.latch   = 1'b0;
    bus.op      = LOAD;
    bus.oe      = 2'b11;
    test_reset();
    test_pipeline();
    test_wrap();
    test_dec_wrap();
    test_oe();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/multilatch_ctr.md
# multilatch_ctr

Parametrised successor to the 12-bit dual-output latch: a two-stage register (capture stage + data stage) of configurable width, with a configurable number of independently enabled output channels and a small op set (load, clear, increment, decrement) executed on the data stage. It sits on the PDP-8 datapath buses as a general register (AC, MQ, PC, MA style), where the increment and clear ops remove the external adder round-trip.

## Interface

Parameters:
- WIDTH, 12, data width of capture stage, data stage and each output channel.
- NOUT, 2, number of output channels, 1..8.

Ports:
- SYSCLK  in  1  single system clock; all state changes on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- in  in  WIDTH  value sampled into the capture stage.
- hold  in  1  1 = capture stage keeps its value; 0 = capture stage loads `in`.
- latch  in  1  1 = execute `op` on the data stage this edge.
- op  in  2  00 LOAD, 01 CLEAR, 10 INC, 11 DEC.
- oe  in  NOUT  per-channel output enable; bit k drives channel k.
- out  out  NOUT*WIDTH  packed channels; channel k is out[k*WIDTH +: WIDTH].
- link  out  1  registered wrap flag.
- zero  out  1  combinational: data stage == 0.

## Operation

- Capture stage `holdreg`: on each edge with hold=0, holdreg <= in. With hold=1, it is unchanged.
- Data stage `data`: with latch=1 on an edge, execute op:
  - LOAD: data <= holdreg; link <= 0.
  - CLEAR: data <= 0; link <= 0.
  - INC: data <= data + 1 mod 2^WIDTH; link <= 1 if data was all-ones, else unchanged.
  - DEC: data <= data - 1 mod 2^WIDTH; link <= 1 if data was 0, else unchanged.
- With latch=0: data and link hold.
- link is sticky. Only LOAD, CLEAR or reset clear it.
- Channel k shows data when oe[k]=1. When oe[k]=0, it shows the disabled value (see Configuration).
- Channels are independent. Any combination of oe bits is legal, including all set.
- zero = (data == 0). It is purely combinational from the data stage and does not depend on oe.

## Timing

- Reset: assertion clears holdreg, data and link immediately, with no clock needed. Consequently zero=1 and each enabled channel outputs 0. Deassertion takes effect at the next rising edge.
- Reset mid-operation wins over any hold, latch or op in flight. The first op after release acts on data=0.
- Pipeline: `in` to data takes 2 edges (capture with hold=0, then LOAD). Data to out is combinational through oe.
- Simultaneous hold=0 and latch=1 with LOAD on the same edge: data takes the OLD holdreg, while holdreg takes the new `in`. There is no bypass.
- INC or DEC on consecutive edges counts once per edge.
- Wrap-around: INC from all-ones gives 0 with link=1. DEC from 0 gives all-ones with link=1.
- zero and out settle combinationally after the edge. oe changes take effect with no clock.

## Configuration

- MULTILATCH_TRISTATE_EN defined: a disabled channel drives 'z on all WIDTH bits. This mode is for shared tristate buses in simulation and for tristate-capable targets.
- MULTILATCH_TRISTATE_EN undefined: a disabled channel drives all zeros, so that channels from several registers can be OR-combined onto a bus on FPGA fabric.
- All other behaviour is identical in both builds.

## Test plan

- Reset: WIDTH=12, NOUT=2, oe=2'b11. Assert RESET_N=0 between edges -> out=0 on both channels, link=0 and zero=1 without any clock edge.
- Pipeline: hold=0, in=12'o1234 at edge 1, then latch=1, op=LOAD at edge 2 -> out channel 0 = 12'o1234 after edge 2, and not after edge 1. Setting hold=0 and LOAD on the same edge with in=12'o7777 -> data still 12'o1234.
- Wrap: LOAD 12'o7777, then INC -> data=0, link=1, zero=1. A following INC -> data=1 with link still 1. A following CLEAR -> link=0.
- DEC wrap: CLEAR then DEC -> data=12'o7777, link=1. A subsequent LOAD of 12'o0005 -> link=0.
- Output enables: data=12'o5252, oe=2'b10 -> channel 1 = 12'o5252, channel 0 = 'z (macro defined) or 0 (macro undefined). Run both builds.
- Reset mid-count: free-run INC, assert RESET_N low mid-cycle -> data=0 at once. Release, then one INC -> data=1, link=0.
